// File: rtl/gan_io_controller.sv
// gan_io_controller
// Serial-to-parallel front end and parallel-to-serial back end for the
// combinational GAN datapath. Input words stream into a register bank that
// drives the datapath's parallel inputs. After a fixed settle time the four
// results are captured and returned as a 4-beat valid/ready stream.
module gan_io_controller #(
    parameter int N_WORDS = 77,  // words per frame, fixed by the datapath
    parameter int DW      = 6,   // signed input word width
    parameter int OW      = 32,  // signed result width
    parameter int SETTLE  = 2    // settle cycles before capture, 1..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_last,
    output logic [N_WORDS*DW-1:0] params,
    input  logic [4*OW-1:0]       f_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OW-1:0]         out_data,
    output logic                  out_last,
    output logic                  err
);

    localparam int             IW          = $clog2(N_WORDS);
    localparam logic [IW-1:0]  LAST_IDX    = IW'(N_WORDS - 1);
    localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [1:0]     LAST_BEAT   = 2'd3;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_SEND
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [IW-1:0]           idx;         // next bank slot to be written
    logic [3:0]              settle_cnt;  // cycles spent in SETTLE so far
    logic [1:0]              beat;        // result beat currently presented
    logic [N_WORDS*DW-1:0]   bank;        // parameter register bank
    logic [4*OW-1:0]         res_buf;     // captured datapath results
    logic                    err_q;

    logic                    in_fire;
    logic                    out_fire;
    logic                    at_end;
    logic                    frame_ok;
    logic                    frame_bad;
    logic                    settle_done;

    // Handshake and framing qualifiers shared by the FSM and the datapath
    always_comb begin
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
        at_end      = (idx == LAST_IDX);
        // A frame is good only when in_last and the final slot coincide;
        // either one without the other is a framing error.
        frame_ok    = in_fire && in_last && at_end;
        frame_bad   = in_fire && (in_last != at_end);
        settle_done = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);
    end

    // State register
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of the order blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: LOAD -> SETTLE -> SEND -> LOAD
    // NOTE: the default assignment at the top keeps this block free of latches
    // on paths where no case branch assigns state_nxt.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD: begin
                if (frame_ok) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_done) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (out_fire && (beat == LAST_BEAT)) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Output decode: handshakes and the beat mux over the result buffer
    always_comb begin
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_SEND);
        out_last  = (state == S_SEND) && (beat == LAST_BEAT);
        out_data  = '0;
        if (state == S_SEND) begin
            unique case (beat)
                2'd0:    out_data = res_buf[0*OW +: OW];
                2'd1:    out_data = res_buf[1*OW +: OW];
                2'd2:    out_data = res_buf[2*OW +: OW];
                default: out_data = res_buf[3*OW +: OW];
            endcase
        end
    end

    // Write index: advances per accepted word, rewinds on any frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (in_fire) begin
            if (in_last || at_end) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Framing error pulse, one cycle after the offending acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= frame_bad;
        end
    end

    // Parameter bank: the accepted word lands at the slot idx points to.
    // Words are stored bit-exact; an error never clears earlier words.
    // NOTE: this bank is an ordinary register array, not a RAM, and it feeds
    // the datapath directly, so it is reset to give the datapath known inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (in_fire) begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (idx == IW'(k)) begin
                    bank[k*DW +: DW] <= in_data;
                end
            end
        end
    end

    // Settle counter: runs only while in SETTLE, cleared otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == S_SETTLE) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Result capture at the end of the last settle cycle; later f_in changes
    // do not disturb the beats being returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_buf <= '0;
        end else if (settle_done) begin
            res_buf <= f_in;
        end
    end

    // Beat index: advances on each accepted beat, parked at 0 outside SEND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (state != S_SEND) begin
            beat <= '0;
        end else if (out_fire) begin
            beat <= beat + 2'd1;
        end
    end

    assign params = bank;
    assign err    = err_q;

endmodule

// File: tb/tb_gan_io_controller.sv
// Testbench for gan_io_controller: randomized word streams and backpressure,
// a behavioural bank/result model, and a scoreboard drained by a monitor.
module tb_gan_io_controller;

    localparam int N_WORDS = 77;
    localparam int DW      = 6;
    localparam int OW      = 32;
    localparam int SETTLE  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic                  in_last;
    logic [N_WORDS*DW-1:0] params;
    logic [4*OW-1:0]       f_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [OW-1:0]         out_data;
    logic                  out_last;
    logic                  err;

    gan_io_controller #(
        .N_WORDS (N_WORDS),
        .DW      (DW),
        .OW      (OW),
        .SETTLE  (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .params    (params),
        .f_in      (f_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    beat_t       sb[$];
    int          n_checks    = 0;
    int          n_errs      = 0;
    int          ready_mode  = 0;   // 0: always ready, 1: 0,0,1 per beat, 2: random
    int          beats_total = 0;

    // Reference model: bank contents and the next slot, by the framing rules
    logic [DW-1:0] mbank [N_WORDS];
    int            midx    = 0;
    bit            exp_err = 1'b0;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N_WORDS*DW-1:0] model_params();
        logic [N_WORDS*DW-1:0] v;
        for (int k = 0; k < N_WORDS; k++) v[k*DW +: DW] = mbank[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_WORDS; k++) mbank[k] = '0;
        midx    = 0;
        exp_err = 1'b0;
    endtask

    // Apply one accepted word to the model; a good frame queues its 4 beats
    task automatic model_accept(input logic [DW-1:0] d, input bit last);
        mbank[midx] = d;
        if (last && midx == N_WORDS - 1) begin
            midx    = 0;
            exp_err = 1'b0;
            for (int b = 0; b < 4; b++) begin
                beat_t e;
                e.data = f_in[b*OW +: OW];
                e.last = (b == 3);
                sb.push_back(e);
            end
        end else if (last || midx == N_WORDS - 1) begin
            midx    = 0;
            exp_err = 1'b1;
        end else begin
            midx++;
            exp_err = 1'b0;
        end
    endtask

    // Present one word (called at posedge+1); returns at posedge+1 after acceptance
    task automatic send_word(input logic [DW-1:0] d, input bit last);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 500) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_accept(d, last);
        check("err_pulse", err, exp_err);
    endtask

    // Full good frame followed by SETTLE/latency checks; returns as beat 0 appears
    task automatic send_frame(input bit ramp, input int gap_max, input bit junk, input bit change_f);
        for (int k = 0; k < N_WORDS; k++) begin
            logic [DW-1:0] d;
            d = ramp ? DW'(k % 64) : DW'($urandom);
            send_word(d, k == N_WORDS - 1);
            if (k != N_WORDS - 1 && gap_max > 0)
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
        check("params_after_frame", params, model_params());
        for (int i = 1; i <= SETTLE; i++) begin
            check("settle_out_valid", out_valid, 0);
            check("settle_in_ready", in_ready, 0);
            if (junk) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
                in_last  = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("out_valid_latency", out_valid, 1);
        if (change_f) f_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && !out_valid && in_ready) break;
            @(posedge clk); #1;
        end
        check("drain_queue_empty", sb.size(), 0);
    endtask

    // out_ready driver, updated just after each rising edge
    initial begin
        int hold = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    if (!out_valid) begin
                        hold      = 0;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = (hold == 2);
                        hold      = (hold == 2) ? 0 : hold + 1;
                    end
                end
                default: out_ready = 1'($urandom);
            endcase
        end
    end

    // Monitor: samples at the falling edge, pops the scoreboard on each accepted beat
    initial begin
        int    vc = 0;
        bit    have_prev = 1'b0;
        beat_t prev;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vc        = 0;
                have_prev = 1'b0;
                continue;
            end
            if (out_valid) begin
                vc++;
                if (have_prev) begin
                    check("hold_data", out_data, prev.data);
                    check("hold_last", out_last, prev.last);
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_last", out_last, e.last);
                        if (ready_mode == 0) check("beat_cycles", vc, 1);
                        else if (ready_mode == 1) check("beat_cycles", vc, 3);
                        beats_total++;
                        if (e.last) begin
                            @(posedge clk); #1;
                            check("in_ready_after_last", in_ready, 1);
                            check("out_valid_after_last", out_valid, 0);
                        end
                    end
                    vc        = 0;
                    have_prev = 1'b0;
                end else begin
                    prev.data = out_data;
                    prev.last = out_last;
                    have_prev = 1'b1;
                end
            end else begin
                if (have_prev) check("valid_held_until_accept", out_valid, 1);
                vc        = 0;
                have_prev = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        bit saw_valid;
        int base;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        f_in     = '0;
        model_reset();

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_params", params, 0);
        check("rst_err", err, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        // Bank mapping with ramp data and fixed results, continuous stream
        ready_mode = 0;
        f_in = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        send_frame(1'b1, 0, 1'b0, 1'b0);
        wait_drain();

        // Backpressure 0,0,1; f_in changes after capture; junk input during SETTLE
        ready_mode = 1;
        f_in = {$urandom, $urandom, $urandom, $urandom};
        send_frame(1'b0, 0, 1'b1, 1'b1);
        wait_drain();
        check("params_after_junk", params, model_params());

        // Framing error: in_last on word 10, then the next word goes to slot 0
        ready_mode = 0;
        for (int k = 0; k <= 10; k++) send_word(DW'($urandom), k == 10);
        send_word(6'h2A, 1'b0);
        check("word_after_err_slot0", params[DW-1:0], 6'h2A);
        check("params_after_err", params, model_params());

        // Framing error: final slot reached without in_last, no SEND follows
        for (int n = 0; n < 100; n++) begin
            send_word(DW'($urandom), 1'b0);
            if (exp_err) break;
        end
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_send_after_err", saw_valid, 0);
        check("in_ready_after_err", in_ready, 1);
        check("params_kept_after_err", params, model_params());

        // Randomized frames with gaps and random backpressure
        for (int f = 0; f < 3; f++) begin
            ready_mode = 2;
            f_in = {$urandom, $urandom, $urandom, $urandom};
            send_frame(1'b0, 2, 1'($urandom), 1'($urandom));
            wait_drain();
        end

        // Asynchronous reset in the middle of SEND
        ready_mode = 0;
        f_in = {$urandom, $urandom, $urandom, $urandom};
        base = beats_total;
        send_frame(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 50 && beats_total < base + 2; i++) begin
            @(posedge clk); #1;
        end
        check("beats_before_reset", beats_total - base, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("midsend_rst_out_valid", out_valid, 0);
        check("midsend_rst_in_ready", in_ready, 1);
        check("midsend_rst_params", params, 0);
        sb.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out_valid", out_valid, 0);
        f_in = {$urandom, $urandom, $urandom, $urandom};
        send_frame(1'b0, 1, 1'b0, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/gan_io_controller.md
# gan_io_controller

Sequential front/back end for the combinational 4-input/4-output GAN datapath. Accepts the 77 signed 6-bit network inputs and parameters as a serial valid/ready word stream and holds them in a register bank that drives the datapath's parallel inputs. Waits a fixed settle time, captures the four 32-bit results, and returns them as a 4-beat valid/ready output stream. It is the only block that talks to the datapath's ports.

## Interface
- N_WORDS, 77, words per input frame (bank depth); fixed by the datapath
- DW, 6, input word width (signed)
- OW, 32, result width (signed)
- SETTLE, 2, wait cycles between bank complete and result capture; legal range 1..15
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready at a rising edge
- in_data  in  DW  input word
- in_last  in  1  marks the final word of a frame
- params  out  N_WORDS*DW  flat register bank; word k is at bits [6k+5:6k]
- f_in  in  4*OW  datapath results; f1 at [31:0], f2 at [63:32], f3 at [95:64], f4 at [127:96]
- out_valid  out  1  result beat valid
- out_ready  in  1  result beat accepted when out_valid && out_ready
- out_data  out  OW  result beat
- out_last  out  1  high on the 4th result beat
- err  out  1  one-cycle pulse on a framing error

## Operation
- Bank order:
  - 0-3: x1..x4
  - 4-19: w_l1_11..w_l1_44, row-major (11,12,13,14,21,...)
  - 20-23: b_l1_1..4
  - 24-31: w_l2_11,12,21,22,31,32,41,42
  - 32-33: b_l2_1,2
  - 34-36: w_l3_11, w_l3_21, b_l3_1
  - 37-38: w_l4_11, b_l4_1
  - 39-40: w_l5_11, b_l5_1
  - 41-44: w_l6_11, w_l6_12, b_l6_1, b_l6_2
  - 45-52: w_l7_11..w_l7_24, row-major
  - 53-56: b_l7_1..4
  - 57-72: w_l8_11..w_l8_44, row-major
  - 73-76: b_l8_1..4
- FSM states LOAD, SETTLE, SEND; reset state LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word is written to bank[idx], then idx increments.
  - If the word is accepted with idx==76 and in_last=1: idx→0, go to SETTLE.
  - If in_last=1 with idx<76, or idx==76 with in_last=0: word is still written, err pulses, idx→0, stay in LOAD.
  - The bank is never cleared on error; partially loaded words persist.
- SETTLE:
  - in_ready=0; the counter counts SETTLE cycles.
  - In the last SETTLE cycle, f_in is registered into a 4×OW result buffer and the state moves to SEND.
- SEND:
  - Beats are f1, f2, f3, f4 from the buffer; beat index 0..3.
  - out_last=1 only on beat 3.
  - Accepting beat 3 returns the FSM to LOAD.
- params always reflects the bank; bank writes take effect the cycle after acceptance.
- No arithmetic in this block; words are passed through bit-exact (sign preserved, no extension).

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, err=0, params=0, idx=0, result buffer=0.
- Reset asserted mid-frame or mid-SEND aborts immediately. No beat completes and the bank clears.
- Final word accepted at edge T:
  - SETTLE covers cycles T+1..T+SETTLE.
  - Capture happens at the edge ending cycle T+SETTLE.
  - out_valid=1 from cycle T+SETTLE+1.
- out_data and out_last hold stable while out_valid && !out_ready; out_valid never drops without acceptance.
- Back-to-back: with out_ready held at 1, SEND takes exactly 4 cycles. in_ready=1 in the cycle after beat 3 is accepted.
- in_valid during SETTLE/SEND is ignored (not accepted, not an error).
- err is asserted in the cycle after the offending acceptance.
- Minimum frame-to-frame period: 77 + SETTLE + 4 cycles.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, release. Expect in_ready=1, out_valid=0, params=0, err=0.
- Bank mapping: stream words with value (k mod 64) for k=0..76, in_last on word 76, in_valid held high.
  - params[6k+5:6k] == k mod 64 for all k.
  - in_ready=0 from the cycle after the last word.
- Capture/stream, SETTLE=2, f_in = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, out_ready=1.
  - out_valid rises exactly 3 cycles after the last-word edge.
  - Beats are AAAA0001, BBBB0002, CCCC0003, DDDD0004, with out_last only on the 4th.
  - in_ready=1 the next cycle.
- Backpressure: out_ready toggles 0,0,1 per beat. Each beat is held for 3 cycles with stable data. Changing f_in after capture does not alter the beats.
- Framing errors:
  - in_last on word 10: err pulses once, the next word lands at bank[0].
  - Word 76 without in_last: err pulses, no SEND.
- Async reset mid-SEND (after beat 1): out_valid=0 immediately, FSM in LOAD, params=0. A subsequent full frame produces 4 correct beats.
